// File: rtl/alu_seq_unit.sv
// Registered execute-stage ALU: single-cycle logic/arithmetic ops plus iterative
// unsigned shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         select,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               overflow,
  output logic               negative,
  output logic               less,
  output logic               equal,
  output logic               zero
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_PASS = 4'd12;

  typedef enum logic {IDLE, ITER} state_e;

  state_e             state_q;
  logic [SW-1:0]      cnt_q;
  logic               mul_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] result_q;
  logic               carry_q, overflow_q, negative_q, less_q, equal_q, zero_q;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   aluLo_d;
  logic               aluCarry_d, aluOverflow_d;
  logic [SW-1:0]      shamt;

  assign shamt = b[SW-1:0];

  // Single-cycle datapath works straight off the live inputs; reserved opcodes fall to zero.
  always_comb begin
    sum           = {1'b0, a} + {1'b0, b};
    diff          = {1'b0, a} - {1'b0, b};
    aluLo_d       = '0;
    aluCarry_d    = 1'b0;
    aluOverflow_d = 1'b0;
    case (select)
      OP_ADD: begin
        aluLo_d       = sum[WIDTH-1:0];
        aluCarry_d    = sum[WIDTH];
        aluOverflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        aluLo_d       = diff[WIDTH-1:0];
        aluCarry_d    = ~diff[WIDTH];
        aluOverflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  aluLo_d = a & b;
      OP_OR:   aluLo_d = a | b;
      OP_XOR:  aluLo_d = a ^ b;
      OP_NOT:  aluLo_d = ~a;
      OP_SLL:  aluLo_d = a << shamt;
      OP_SRL:  aluLo_d = a >> shamt;
      OP_SRA:  aluLo_d = $signed(a) >>> shamt;
      OP_SLT:  aluLo_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASS: aluLo_d = b;
      default: aluLo_d = '0;
    endcase
  end

  logic               curMul;
  logic [WIDTH-1:0]   curHi, curLo, curOpA, curOpB;
  logic [WIDTH:0]     mulSum, divTrial, divDiff;
  logic [WIDTH-1:0]   stepHi_d, stepLo_d;

  // One multiply/divide step; the first step runs on acceptance from the raw inputs.
  always_comb begin
    if (state_q == IDLE) begin
      curMul = (select == OP_MUL);
      curHi  = '0;
      curLo  = curMul ? b : a;
      curOpA = a;
      curOpB = b;
    end else begin
      curMul = mul_q;
      curHi  = hi_q;
      curLo  = lo_q;
      curOpA = a_q;
      curOpB = b_q;
    end
    mulSum   = {1'b0, curHi} + (curLo[0] ? {1'b0, curOpA} : {(WIDTH+1){1'b0}});
    divTrial = {curHi, curLo[WIDTH-1]};
    divDiff  = divTrial - {1'b0, curOpB};
    if (curMul) begin
      stepHi_d = mulSum[WIDTH:1];
      stepLo_d = {mulSum[0], curLo[WIDTH-1:1]};
    end else if (divTrial >= {1'b0, curOpB}) begin
      stepHi_d = divDiff[WIDTH-1:0];
      stepLo_d = {curLo[WIDTH-2:0], 1'b1};
    end else begin
      stepHi_d = divTrial[WIDTH-1:0];
      stepLo_d = {curLo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mul_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
      less_q     <= 1'b0;
      equal_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            if (select == OP_MUL || select == OP_DIV) begin
              state_q <= ITER;
              busy_q  <= 1'b1;
              mul_q   <= (select == OP_MUL);
              cnt_q   <= SW'(WIDTH - 1);
              hi_q    <= stepHi_d;
              lo_q    <= stepLo_d;
            end else begin
              done_q     <= 1'b1;
              result_q   <= {{WIDTH{1'b0}}, aluLo_d};
              carry_q    <= aluCarry_d;
              overflow_q <= aluOverflow_d;
              negative_q <= aluLo_d[WIDTH-1];
              zero_q     <= ~|aluLo_d;
              less_q     <= $signed(a) < $signed(b);
              equal_q    <= (a == b);
            end
          end
        end
        ITER: begin
          if (cnt_q == SW'(1)) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            result_q   <= {stepHi_d, stepLo_d};
            carry_q    <= 1'b0;
            overflow_q <= mul_q ? (|stepHi_d) : (b_q == '0);
            negative_q <= mul_q ? stepHi_d[WIDTH-1] : stepLo_d[WIDTH-1];
            zero_q     <= ~|{stepHi_d, stepLo_d};
            less_q     <= $signed(a_q) < $signed(b_q);
            equal_q    <= (a_q == b_q);
          end else begin
            cnt_q <= cnt_q - SW'(1);
            hi_q  <= stepHi_d;
            lo_q  <= stepLo_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign negative = negative_q;
  assign less     = less_q;
  assign equal    = equal_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Testbench for alu_seq_unit (WIDTH=8): table of hand-computed vectors, handshake
// corner sequences and random ops checked through an expected-result queue.
module tb_alu_seq_unit;

  typedef struct packed {
    logic [15:0] result;
    logic [5:0]  flags;   // {carry, overflow, negative, less, equal, zero}
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a, b;
  logic [3:0]  select;
  logic        busy, done;
  logic [15:0] result;
  logic        carry, overflow, negative, less, equal, zero;

  int   checks;
  int   failures;
  exp_t expQ[$];
  exp_t monExp;

  alu_seq_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .select(select),
    .busy(busy), .done(done), .result(result), .carry(carry), .overflow(overflow),
    .negative(negative), .less(less), .equal(equal), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Independent reference built on integer arithmetic.
  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [3:0] ms);
    exp_t e;
    int sa, sb, full;
    logic [15:0] r;
    logic c, o, n;
    logic [2:0] sh;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    sh = mb[2:0];
    r = 16'h0; c = 1'b0; o = 1'b0;
    case (ms)
      4'd0: begin
        full = int'(ma) + int'(mb);
        r = {8'h00, 8'(full)}; c = (full > 255); o = (sa + sb > 127) || (sa + sb < -128);
      end
      4'd1: begin
        full = int'(ma) - int'(mb);
        r = {8'h00, 8'(full)}; c = (ma >= mb); o = (sa - sb > 127) || (sa - sb < -128);
      end
      4'd2:  r = {8'h00, ma & mb};
      4'd3:  r = {8'h00, ma | mb};
      4'd4:  r = {8'h00, ma ^ mb};
      4'd5:  r = {8'h00, ~ma};
      4'd6:  r = {8'h00, 8'(ma << sh)};
      4'd7:  r = {8'h00, 8'(ma >> sh)};
      4'd8:  r = {8'h00, 8'(sa >>> sh)};
      4'd9:  r = (sa < sb) ? 16'd1 : 16'd0;
      4'd10: begin
        full = int'(ma) * int'(mb);
        r = 16'(full); o = (full > 255);
      end
      4'd11: begin
        if (mb == 8'd0) begin
          r = {ma, 8'hFF}; o = 1'b1;
        end else begin
          r = {8'(int'(ma) % int'(mb)), 8'(int'(ma) / int'(mb))};
        end
      end
      4'd12: r = {8'h00, mb};
      default: r = 16'h0;
    endcase
    n = (ms == 4'd10) ? r[15] : r[7];
    e.result = r;
    e.flags  = {c, o, n, (sa < sb), (ma == mb), (r == 16'h0)};
    return e;
  endfunction

  function automatic vec_t mkVec(input logic [3:0] s, input logic [7:0] va, input logic [7:0] vb,
                                 input logic [15:0] r, input logic [5:0] f);
    vec_t v;
    v.sel = s; v.a = va; v.b = vb; v.e.result = r; v.e.flags = f;
    return v;
  endfunction

  // Scoreboard: every done pulse consumes the oldest expected record.
  always @(negedge clk) begin
    if (done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("result", 32'(result), 32'(monExp.result));
        checkOutput("flags", 32'({carry, overflow, negative, less, equal, zero}), 32'(monExp.flags));
      end
    end
  end

  // Issue one op at a negedge and wait (bounded) for done; pokeCycle>0 pulses a stray start mid-op.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tbv, input logic [3:0] ts,
                               input exp_t e, input int pokeCycle);
    int lat, busyCnt, expLat;
    a = ta; b = tbv; select = ts; start = 1'b1;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busyCnt = 0;
    while (!done && lat < 20) begin
      if (busy) busyCnt++;
      if (lat == pokeCycle) begin
        start = 1'b1; a = 8'h5A; b = 8'h33; select = 4'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    expLat = (ts == 4'd10 || ts == 4'd11) ? 8 : 1;
    if (!done) begin
      checkOutput("done_timeout", 32'(done), 32'd1);
      expQ.delete();
    end else begin
      checkOutput("latency", 32'(lat), 32'(expLat));
      checkOutput("busy_cycles", 32'(busyCnt), 32'(expLat - 1));
      checkOutput("busy_at_done", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[18];
    logic [3:0] bbSel[3];
    exp_t bbExp[3];
    int doneCnt;
    logic [7:0] ra, rb;
    logic [3:0] rs;

    vecs[0]  = mkVec(4'd0,  8'd200, 8'd100, 16'h002C, 6'b100100);
    vecs[1]  = mkVec(4'd0,  8'd100, 8'd50,  16'h0096, 6'b011000);
    vecs[2]  = mkVec(4'd1,  8'd100, 8'd120, 16'h00EC, 6'b001100);
    vecs[3]  = mkVec(4'd10, 8'd200, 8'd100, 16'h4E20, 6'b010100);
    vecs[4]  = mkVec(4'd11, 8'd200, 8'd7,   16'h041C, 6'b000100);
    vecs[5]  = mkVec(4'd11, 8'd13,  8'd0,   16'h0DFF, 6'b011000);
    vecs[6]  = mkVec(4'd1,  8'd55,  8'd55,  16'h0000, 6'b100011);
    vecs[7]  = mkVec(4'd2,  8'hF0,  8'h3C,  16'h0030, 6'b000100);
    vecs[8]  = mkVec(4'd3,  8'h0F,  8'h80,  16'h008F, 6'b001000);
    vecs[9]  = mkVec(4'd5,  8'h55,  8'h00,  16'h00AA, 6'b001000);
    vecs[10] = mkVec(4'd7,  8'h81,  8'h03,  16'h0010, 6'b000100);
    vecs[11] = mkVec(4'd9,  8'hFE,  8'h01,  16'h0001, 6'b000100);
    vecs[12] = mkVec(4'd12, 8'h03,  8'h9C,  16'h009C, 6'b001000);
    vecs[13] = mkVec(4'd14, 8'h07,  8'h07,  16'h0000, 6'b000011);
    vecs[14] = mkVec(4'd10, 8'd15,  8'd17,  16'h00FF, 6'b000100);
    vecs[15] = mkVec(4'd6,  8'h81,  8'h09,  16'h0002, 6'b000100);
    vecs[16] = mkVec(4'd8,  8'h90,  8'h02,  16'h00E4, 6'b001100);
    vecs[17] = mkVec(4'd0,  8'h80,  8'h80,  16'h0000, 6'b110011);

    bbSel[0] = 4'd4; bbExp[0].result = 16'h0080; bbExp[0].flags = 6'b001100;
    bbSel[1] = 4'd6; bbExp[1].result = 16'h0002; bbExp[1].flags = 6'b000100;
    bbSel[2] = 4'd8; bbExp[2].result = 16'h00C0; bbExp[2].flags = 6'b001100;

    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; a = 8'h0; b = 8'h0; select = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 32'({busy, done, result, carry, overflow, negative, less, equal, zero}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].e, 0);

    $display("[TB] MUL with stray start mid-operation");
    applyStimulus(8'd200, 8'd100, 4'd10, mkVec(4'd10, 8'd0, 8'd0, 16'h4E20, 6'b010100).e, 3);
    repeat (3) @(negedge clk);

    $display("[TB] back-to-back single-cycle ops");
    doneCnt = 0;
    a = 8'h81; b = 8'h01; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      select = bbSel[i];
      expQ.push_back(bbExp[i]);
      @(negedge clk);
      if (done) doneCnt++;
    end
    start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_done_count", 32'(doneCnt), 32'd3);
    checkOutput("b2b_done_after", 32'(done), 32'd0);

    $display("[TB] reset during MUL");
    a = 8'd200; b = 8'd100; select = 4'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_state", 32'({busy, done, result, carry, overflow, negative, less, equal, zero}), 32'd0);
    reset = 1'b0;
    doneCnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
    applyStimulus(8'd1, 8'd1, 4'd0, mkVec(4'd0, 8'd0, 8'd0, 16'h0002, 6'b000010).e, 0);

    $display("[TB] random ops");
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 4'($urandom_range(0, 15));
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 0) rb = 8'd0;
      applyStimulus(ra, rb, rs, model(ra, rb, rs), 0);
    end

    repeat (2) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
